// File: rtl/timed_memory_if.sv
// ============================================================================
//  Module      : timed_memory_if
//  Description : Request/response bundle for both ports of timed_memory.
//                The instruction (i_) and data (d_) ports have identical
//                shape. The access counters are present only when the
//                macro TIMED_MEMORY_COUNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface timed_memory_if #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 8
) ();
    // Instruction port
    logic                  i_readM;
    logic                  i_writeM;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [WORD_SIZE-1:0]  i_wdata;
    logic [WORD_SIZE-1:0]  i_rdata;
    logic                  i_ready;
    // Data port
    logic                  d_readM;
    logic                  d_writeM;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [WORD_SIZE-1:0]  d_wdata;
    logic [WORD_SIZE-1:0]  d_rdata;
    logic                  d_ready;
`ifdef TIMED_MEMORY_COUNT_EN
    logic [15:0]           i_acc_count;
    logic [15:0]           d_acc_count;
`endif

    // Requester side
    modport master (
        output i_readM, i_writeM, i_address, i_wdata,
        input  i_rdata, i_ready,
        output d_readM, d_writeM, d_address, d_wdata,
        input  d_rdata, d_ready
`ifdef TIMED_MEMORY_COUNT_EN
        , input i_acc_count, d_acc_count
`endif
    );

    // Memory side
    modport slave (
        input  i_readM, i_writeM, i_address, i_wdata,
        output i_rdata, i_ready,
        input  d_readM, d_writeM, d_address, d_wdata,
        output d_rdata, d_ready
`ifdef TIMED_MEMORY_COUNT_EN
        , output i_acc_count, d_acc_count
`endif
    );
endinterface

`default_nettype wire

// File: rtl/timed_memory.sv
// ============================================================================
//  Module      : timed_memory
//  Description : Dual-port word memory with a fixed access latency. Each
//                port (0 = instruction, 1 = data) runs an IDLE/BUSY/DONE
//                FSM; the access happens LATENCY edges after acceptance and
//                ready pulses for one cycle. Same-edge collisions: reads see
//                pre-write data, the data-port write wins over the
//                instruction-port write.
//                Optional feature macro: TIMED_MEMORY_COUNT_EN adds 16-bit
//                saturating per-port access counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timed_memory #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2     // legal range 1..15
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    timed_memory_if.slave     bus
);
    localparam int         c_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Per-port state, index 0 = instruction port, 1 = data port
    state_t                r_state     [2];
    state_t                w_state_nxt [2];
    logic [3:0]            r_cnt       [2];
    logic                  r_op_wr     [2];
    logic [ADDR_WIDTH-1:0] r_addr      [2];
    logic [WORD_SIZE-1:0]  r_wdata     [2];
    logic [WORD_SIZE-1:0]  r_rdata     [2];
    logic                  r_ready     [2];

    logic                  w_req_rd    [2];
    logic                  w_req_wr    [2];
    logic [ADDR_WIDTH-1:0] w_req_addr  [2];
    logic [WORD_SIZE-1:0]  w_req_wdata [2];
    logic                  w_accept    [2];
    logic                  w_access    [2];

    logic [WORD_SIZE-1:0]  r_mem [c_DEPTH];

    assign w_req_rd[0]    = bus.i_readM;
    assign w_req_wr[0]    = bus.i_writeM;
    assign w_req_addr[0]  = bus.i_address;
    assign w_req_wdata[0] = bus.i_wdata;
    assign w_req_rd[1]    = bus.d_readM;
    assign w_req_wr[1]    = bus.d_writeM;
    assign w_req_addr[1]  = bus.d_address;
    assign w_req_wdata[1] = bus.d_wdata;

    // Next-state logic: accept in IDLE, access when the count reaches LATENCY
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_state_nxt[p] = r_state[p];
            w_accept[p]    = 1'b0;
            w_access[p]    = 1'b0;
            case (r_state[p])
                ST_IDLE: begin
                    if (w_req_rd[p] || w_req_wr[p]) begin
                        w_accept[p]    = 1'b1;
                        w_state_nxt[p] = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt[p] == c_LAT) begin
                        w_access[p]    = 1'b1;
                        w_state_nxt[p] = ST_DONE;
                    end
                end
                ST_DONE: w_state_nxt[p] = ST_IDLE;
                default: w_state_nxt[p] = ST_IDLE;
            endcase
        end
    end

    // State, latency counter, ready pulse and read data registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                r_state[p] <= ST_IDLE;
                r_cnt[p]   <= 4'd0;
                r_ready[p] <= 1'b0;
                r_rdata[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_state[p] <= w_state_nxt[p];
                r_ready[p] <= w_access[p];
                if (w_accept[p]) begin
                    r_cnt[p] <= 4'd1;
                end else if (r_state[p] == ST_BUSY && r_cnt[p] < c_LAT) begin
                    r_cnt[p] <= r_cnt[p] + 4'd1;
                end
                // Non-blocking read of the array gives pre-write data on collisions
                if (w_access[p] && !r_op_wr[p]) begin
                    r_rdata[p] <= r_mem[r_addr[p]];
                end
            end
        end
    end

    // Request capture at acceptance; a simultaneous read+write becomes a write
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (w_accept[p]) begin
                r_op_wr[p] <= w_req_wr[p];
                r_addr[p]  <= w_req_addr[p];
                r_wdata[p] <= w_req_wdata[p];
            end
        end
    end

    // Array writes; the data port is applied last so it wins a collision
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (w_access[p] && r_op_wr[p]) begin
                r_mem[r_addr[p]] <= r_wdata[p];
            end
        end
    end

    assign bus.i_rdata = r_rdata[0];
    assign bus.i_ready = r_ready[0];
    assign bus.d_rdata = r_rdata[1];
    assign bus.d_ready = r_ready[1];

`ifdef TIMED_MEMORY_COUNT_EN
    logic [15:0] r_acc_cnt [2];

    // Saturating count of completed accesses per port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                r_acc_cnt[p] <= 16'd0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_access[p] && r_acc_cnt[p] != 16'hFFFF) begin
                    r_acc_cnt[p] <= r_acc_cnt[p] + 16'd1;
                end
            end
        end
    end

    assign bus.i_acc_count = r_acc_cnt[0];
    assign bus.d_acc_count = r_acc_cnt[1];
`endif

endmodule

`default_nettype wire
